mult_arbiter: RTL



---
 rtl/mult_arb_pkg.sv | 15 +
 rtl/mult_arbiter_if.sv | 28 ++
 rtl/mult7_core.sv | 70 +++++++
 rtl/mult_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared defaults, core latency and FSM state type for the shared scale-by-7 multiplier arbiter.
package mult_arb_pkg;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned W        = 21;
  localparam int unsigned RW       = 2 * W + 3;
  localparam int unsigned CORE_LAT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_arbiter_if.sv
// Client-side bus of mult_arbiter: per-requester request/operands in, grant and tagged result out.
interface mult_arbiter_if #(
  parameter int unsigned NREQ = mult_arb_pkg::NREQ,
  parameter int unsigned W    = mult_arb_pkg::W,
  parameter int unsigned RW   = mult_arb_pkg::RW,
  parameter int unsigned IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [RW-1:0]     result;

  modport master (
    output req, a_in, b_in,
    input  gnt, busy, res_valid, res_id, result
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, busy, res_valid, res_id, result
  );

endinterface

// File: rtl/mult7_core.sv
// Multi-cycle A*B*7 core: product in the first cycle, then P+2P and +4P accumulate, done after LAT cycles.
module mult7_core
  import mult_arb_pkg::*;
#(
  parameter int unsigned W   = mult_arb_pkg::W,
  parameter int unsigned RW  = mult_arb_pkg::RW,
  parameter int unsigned LAT = mult_arb_pkg::CORE_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          done,
  output logic [RW-1:0] p
);

  localparam int unsigned CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] prod_q, prod_d;
  logic [RW-1:0] acc_q, acc_d;
  logic          done_q, done_d;

  // cnt_q == 0 means idle; start is ignored while a job is in flight
  always_comb begin
    cnt_d  = cnt_q;
    prod_d = prod_q;
    acc_d  = acc_q;
    done_d = 1'b0;
    if (cnt_q == '0) begin
      if (start) begin
        prod_d = RW'(a) * RW'(b);
        acc_d  = RW'(a) * RW'(b);
        cnt_d  = CW'(1);
      end
    end else begin
      if (cnt_q == CW'(1)) begin
        acc_d = acc_q + (prod_q << 1);
      end else if (cnt_q == CW'(2)) begin
        acc_d = acc_q + (prod_q << 2);
      end
      if (cnt_q == LAST) begin
        done_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      prod_q <= '0;
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
      acc_q  <= acc_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign p    = acc_q;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one mult7_core among NREQ requesters; broadcasts tagged results.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned NREQ = mult_arb_pkg::NREQ,
  parameter int unsigned W    = mult_arb_pkg::W,
  parameter int unsigned RW   = mult_arb_pkg::RW,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input logic           clk,
  input logic           rst,
  mult_arbiter_if.slave bus
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            res_valid_q, res_valid_d;
  logic            start_q, start_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [RW-1:0]   result_q, result_d;

  logic            core_done;
  logic [RW-1:0]   core_p;

  logic [NREQ-1:0] rot;
  logic            found;
  int unsigned     win;
  logic [NREQ-1:0] onehot;
  logic [W-1:0]    sel_a, sel_b;
  logic [IDW-1:0]  nxt_ptr;

  // Rotate requests so bit 0 is req[ptr]; first set bit is the round-robin winner.
  always_comb begin
    rot   = NREQ'({bus.req, bus.req} >> ptr_q);
    found = 1'b0;
    win   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        win   = 32'(ptr_q) + k;
      end
    end
    if (win >= NREQ) begin
      win = win - NREQ;
    end
    onehot = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == i) begin
        onehot[i] = 1'b1;
        sel_a     = bus.a_in[i*W +: W];
        sel_b     = bus.b_in[i*W +: W];
      end
    end
    nxt_ptr = (win == NREQ - 1) ? '0 : IDW'(win + 1);
  end

  // DONE arbitrates like IDLE so a pending request is granted right after the result cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    res_id_d    = res_id_q;
    gnt_d       = '0;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    start_d     = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (found) begin
          state_d = RUN;
          gnt_d   = onehot;
          busy_d  = 1'b1;
          start_d = 1'b1;
          a_d     = sel_a;
          b_d     = sel_b;
          id_d    = IDW'(win);
          ptr_d   = nxt_ptr;
        end
      end
      RUN: begin
        if (core_done) begin
          state_d     = DONE;
          result_d    = core_p;
          res_id_d    = id_q;
          res_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      res_id_q    <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      start_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      res_id_q    <= res_id_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      start_q     <= start_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
    end
  end

  mult7_core #(
    .W  (W),
    .RW (RW),
    .LAT(CORE_LAT)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .start(start_q),
    .a    (a_q),
    .b    (b_q),
    .done (core_done),
    .p    (core_p)
  );

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.result    = result_q;

endmodule
